// File: rtl/dff_en_clr.sv
// Rising-edge D register with synchronous load enable and asynchronous clear.
// One instance per stage of the serial shift-register chain.
module dff_en_clr #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  // CLR sits in the sensitivity list, so it wins over any edge in the same timestep
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      Q <= CLR_VALUE;
    end else if (EN) begin
      Q <= D;
    end
  end

endmodule

// File: tb/tb_dff_en_clr.sv
// Directed test for dff_en_clr: one 1-bit cell with the default clear value and
// one 8-bit cell with clear value 8'hA5, sharing a manually toggled clock.
module tb_dff_en_clr;

  logic       clk;
  logic       clr1, en1, d1, q1;
  logic       clr8, en8;
  logic [7:0] d8, q8;

  int compared   = 0;
  int mismatched = 0;

  dff_en_clr u1 (
    .CLK (clk),
    .CLR (clr1),
    .EN  (en1),
    .D   (d1),
    .Q   (q1)
  );

  dff_en_clr #(
    .WIDTH     (8),
    .CLR_VALUE (8'hA5)
  ) u8 (
    .CLK (clk),
    .CLR (clr8),
    .EN  (en8),
    .D   (d8),
    .Q   (q8)
  );

  // One full clock period; the check that follows runs with the clock low again.
  task automatic tick();
    clk = 1'b1;
    #5;
    clk = 1'b0;
    #5;
  endtask

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
    $display("step %-18s observed %h expected %h", tag, observed, expected);
  endtask

  initial begin
    clk  = 1'b0;
    clr1 = 1'b0; en1 = 1'b0; d1 = 1'b0;
    clr8 = 1'b0; en8 = 1'b0; d8 = 8'h00;
    #10;

    // Power-up clear with no clock edge
    clr1 = 1'b1;
    #1  check("pwr_clr_during", {7'b0, q1}, 8'h00);
    #49 clr1 = 1'b0;
    #1  check("pwr_clr_after", {7'b0, q1}, 8'h00);

    // Enabled load
    en1 = 1'b1; d1 = 1'b1; tick();
    check("load_1", {7'b0, q1}, 8'h01);
    d1 = 1'b0; tick();
    check("load_0", {7'b0, q1}, 8'h00);

    // Hold
    en1 = 1'b0; d1 = 1'b1; tick();
    check("hold_d1", {7'b0, q1}, 8'h00);
    d1 = 1'b0; tick();
    check("hold_d0", {7'b0, q1}, 8'h00);

    // Load, then D changes between edges, then async clear with clock low
    en1 = 1'b1; d1 = 1'b1; tick();
    check("reload_1", {7'b0, q1}, 8'h01);
    d1 = 1'b0;
    #3  check("d_between_edges", {7'b0, q1}, 8'h01);
    clr1 = 1'b1;
    #1  check("async_clr_now", {7'b0, q1}, 8'h00);
    #49 clr1 = 1'b0;
    #1  check("async_clr_after", {7'b0, q1}, 8'h00);
    en1 = 1'b0; d1 = 1'b1; tick();
    check("post_clr_hold", {7'b0, q1}, 8'h00);
    en1 = 1'b1; tick();
    check("post_clr_load", {7'b0, q1}, 8'h01);

    // Clear priority over enabled edges
    clr1 = 1'b1; en1 = 1'b1; d1 = 1'b1;
    #1 check("clr_prio_0", {7'b0, q1}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("clr_prio_edge%0d", i), {7'b0, q1}, 8'h00);
    end
    clr1 = 1'b0;
    #5;

    // Clock edge and clear rising in the same timestep
    en1 = 1'b1; d1 = 1'b1;
    clr1 = 1'b1;
    clk  = 1'b1;
    #1 check("clr_same_edge", {7'b0, q1}, 8'h00);
    #4 clk = 1'b0;
    #5 clr1 = 1'b0;
    #1 check("clr_same_after", {7'b0, q1}, 8'h00);

    // 8-bit cell with non-zero clear value
    clr8 = 1'b1;
    #1  check("w8_clr_during", q8, 8'hA5);
    #49 clr8 = 1'b0;
    #1  check("w8_clr_after", q8, 8'hA5);
    en8 = 1'b1; d8 = 8'h3C; tick();
    check("w8_load", q8, 8'h3C);
    en8 = 1'b0; d8 = 8'hFF; tick();
    check("w8_hold", q8, 8'h3C);
    en8 = 1'b1; d8 = 8'hC3; tick();
    check("w8_load2", q8, 8'hC3);
    clr8 = 1'b1;
    #1  check("w8_async_clr", q8, 8'hA5);
    #9  clr8 = 1'b0;
    #1;
    tick();
    check("w8_load_after_clr", q8, 8'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
